// File: rtl/tf_pkg.sv
// ---------------------------------------------------------------------------
// tf_pkg -- shared definitions for the twiddle-factor generator.
//   tf_state_e     : command FSM states (IDLE, ARMED, RUN)
//   DEF_*          : default parameter values for tf_gen / mod_mul
//   CFG_SEL_*      : cfg_sel encodings selecting the table to write
// ---------------------------------------------------------------------------
package tf_pkg;

  localparam int DEF_P_WIDTH = 14;     // twiddle / modulus width
  localparam int DEF_Q       = 12289;  // NTT prime modulus
  localparam int DEF_STAGES  = 4;      // table depth
  localparam int DEF_D_WIDTH = 4;      // it_depth_cnt / tf_cnt width

  localparam logic CFG_SEL_ROOT = 1'b0;  // write root_tbl (step roots)
  localparam logic CFG_SEL_GRP  = 1'b1;  // write grp_tbl (group roots)

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } tf_state_e;

endpackage

// File: rtl/mod_mul.sv
// ---------------------------------------------------------------------------
// mod_mul -- combinational modular multiplier, p = (a * b) mod Q.
//   a, b : operands, each expected to be < Q
//   p    : reduced product, always < Q
// The product is formed at full 2*P_WIDTH width so nothing is lost before
// the reduction.
// ---------------------------------------------------------------------------
module mod_mul #(
  parameter int P_WIDTH = 14,
  parameter int Q       = 12289
) (
  input  logic [P_WIDTH-1:0] a,
  input  logic [P_WIDTH-1:0] b,
  output logic [P_WIDTH-1:0] p
);

  localparam int PW2 = 2 * P_WIDTH;
  localparam logic [PW2-1:0] Q_W = PW2'(Q);

  logic [PW2-1:0] prod_s;
  logic [PW2-1:0] rem_s;

  // Full-width product followed by reduction modulo Q.
  always_comb begin
    prod_s = PW2'(a) * PW2'(b);
    rem_s  = prod_s % Q_W;
    p      = P_WIDTH'(rem_s);
  end

endmodule

// File: rtl/tf_gen.sv
// ---------------------------------------------------------------------------
// tf_gen -- twiddle-factor generator driven by the NTT controller.
// Keeps a running base (advanced by the stage step root on every TF_ren) and
// a group base (advanced by the stage group root on every TF_wen).
//   clk, rst       : clock, synchronous active-high reset
//   TF_init_base   : running base and group base back to 1, FSM -> ARMED
//   TF_init_const  : latch stage from it_depth_cnt, load step root
//   TF_ren         : emit current base on tf_out (1-cycle latency), advance
//   TF_wen         : end of BU group, advance group base, restart base
//   it_depth_cnt   : stage index from the controller
//   cfg_we/sel/addr/data : table write port, accepted only in IDLE
//   tf_out/tf_valid: twiddle factor and its valid strobe
//   tf_cnt         : twiddles emitted since last init/wen (wraps)
//   cfg_err        : sticky config / stage-index error
// ---------------------------------------------------------------------------
module tf_gen
  import tf_pkg::*;
#(
  parameter int P_WIDTH = DEF_P_WIDTH,
  parameter int Q       = DEF_Q,
  parameter int STAGES  = DEF_STAGES,
  parameter int D_WIDTH = DEF_D_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       TF_init_base,
  input  logic                       TF_init_const,
  input  logic                       TF_ren,
  input  logic                       TF_wen,
  input  logic [D_WIDTH-1:0]         it_depth_cnt,
  input  logic                       cfg_we,
  input  logic                       cfg_sel,
  input  logic [$clog2(STAGES)-1:0]  cfg_addr,
  input  logic [P_WIDTH-1:0]         cfg_data,
  output logic [P_WIDTH-1:0]         tf_out,
  output logic                       tf_valid,
  output logic [D_WIDTH-1:0]         tf_cnt,
  output logic                       cfg_err
);

  localparam int AW = $clog2(STAGES);
  localparam logic [P_WIDTH-1:0] P_ONE   = {{(P_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [D_WIDTH-1:0] CNT_ONE = {{(D_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [D_WIDTH-1:0] CNT_ZERO = {D_WIDTH{1'b0}};

  logic [P_WIDTH-1:0] root_tbl_r [STAGES];
  logic [P_WIDTH-1:0] grp_tbl_r  [STAGES];

  tf_state_e          state_r;
  tf_state_e          state_nxt_s;
  logic [P_WIDTH-1:0] base_r;
  logic [P_WIDTH-1:0] grp_r;
  logic [P_WIDTH-1:0] step_r;
  logic [D_WIDTH-1:0] stage_r;

  logic               depth_bad_s;
  logic [AW-1:0]      idx_s;
  logic               init_any_s;
  logic               ren_acc_s;
  logic               wen_acc_s;
  logic [P_WIDTH-1:0] base_step_s;
  logic [P_WIDTH-1:0] grp_next_s;

  // Stage index clamp and command acceptance; init commands mask wen/ren.
  always_comb begin
    depth_bad_s = (int'(it_depth_cnt) >= STAGES);
    if (depth_bad_s) begin
      idx_s = AW'(STAGES - 1);
    end else begin
      idx_s = AW'(it_depth_cnt);
    end
    init_any_s = TF_init_base | TF_init_const;
    wen_acc_s  = TF_wen & (state_r != IDLE) & ~init_any_s;
    ren_acc_s  = TF_ren & (state_r != IDLE) & ~init_any_s;
  end

  mod_mul #(.P_WIDTH(P_WIDTH), .Q(Q)) u_base_mul (
    .a (base_r),
    .b (step_r),
    .p (base_step_s)
  );

  mod_mul #(.P_WIDTH(P_WIDTH), .Q(Q)) u_grp_mul (
    .a (grp_r),
    .b (grp_tbl_r[idx_s]),
    .p (grp_next_s)
  );

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (TF_init_base) begin
          state_nxt_s = ARMED;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ARMED: begin
        if (TF_init_base) begin
          state_nxt_s = ARMED;
        end else if (ren_acc_s) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = ARMED;
        end
      end
      RUN: begin
        if (TF_init_base) begin
          state_nxt_s = ARMED;
        end else if (wen_acc_s && !ren_acc_s) begin
          state_nxt_s = ARMED;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Root / group tables, writable only while IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        root_tbl_r[i] <= P_ONE;
        grp_tbl_r[i]  <= P_ONE;
      end
    end else if (cfg_we && (state_r == IDLE)) begin
      if (cfg_sel == CFG_SEL_GRP) begin
        grp_tbl_r[cfg_addr] <= cfg_data;
      end else begin
        root_tbl_r[cfg_addr] <= cfg_data;
      end
    end
  end

  // Sticky error: late table write or out-of-range stage index.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_err <= 1'b0;
    end else if ((cfg_we && (state_r != IDLE)) ||
                 ((TF_init_const || wen_acc_s) && depth_bad_s)) begin
      cfg_err <= 1'b1;
    end
  end

  // Stage and step root; a wen only reloads when the stage actually moves.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_r <= CNT_ZERO;
      step_r  <= P_ONE;
    end else if (TF_init_const) begin
      stage_r <= it_depth_cnt;
      step_r  <= root_tbl_r[idx_s];
    end else if (wen_acc_s && (it_depth_cnt != stage_r)) begin
      stage_r <= it_depth_cnt;
      step_r  <= root_tbl_r[idx_s];
    end
  end

  // Running base, group base and emit counter; wen overrides ren's advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_r <= P_ONE;
      grp_r  <= P_ONE;
      tf_cnt <= CNT_ZERO;
    end else if (TF_init_base) begin
      base_r <= P_ONE;
      grp_r  <= P_ONE;
      tf_cnt <= CNT_ZERO;
    end else if (wen_acc_s) begin
      base_r <= grp_next_s;
      grp_r  <= grp_next_s;
      tf_cnt <= CNT_ZERO;
    end else if (ren_acc_s) begin
      base_r <= base_step_s;
      tf_cnt <= tf_cnt + CNT_ONE;
    end
  end

  // Registered twiddle output; tf_out holds between emits.
  always_ff @(posedge clk) begin
    if (rst) begin
      tf_out   <= {P_WIDTH{1'b0}};
      tf_valid <= 1'b0;
    end else begin
      tf_valid <= ren_acc_s;
      if (ren_acc_s) begin
        tf_out <= base_r;
      end
    end
  end

endmodule
